// File: rtl/minx_bus_pkg.sv
// Shared bus encodings and fabric state type for the Pokemon mini SoC.
// Imported by the fabric, the s1c88 core, the PRC and the minx top.
package minx_bus_pkg;

    localparam logic [1:0] BUS_IDLE      = 2'b00;
    localparam logic [1:0] BUS_IRQ_READ  = 2'b01;
    localparam logic [1:0] BUS_MEM_WRITE = 2'b10;
    localparam logic [1:0] BUS_MEM_READ  = 2'b11;

    localparam logic [23:0] REG_BASE_DEFAULT = 24'h2000;
    localparam int          REG_WINDOW       = 256;

    typedef enum logic [2:0] {
        FAB_OWNER,
        FAB_YIELD_WAIT,
        FAB_GRANT,
        FAB_HANDOVER,
        FAB_RETURN
    } fab_state_t;

    // Widened to 25 bits so a base near the top of memory cannot wrap
    function automatic logic in_reg_window(
        input logic [23:0] addr,
        input logic [23:0] base
    );
        logic [24:0] a;
        logic [24:0] lo;
        logic [24:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + 25'(REG_WINDOW);
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/minx_arb_pick.sv
// Combinational winner select among the non-owner masters.
// Mode 0 picks the lowest index; mode 1 rotates after the last grant.
module minx_arb_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0] pending,
    input  logic [2:0]   last,
    input  logic         mode,
    output logic [N-1:0] winner,
    output logic [2:0]   win_idx,
    output logic         valid
);

    logic [7:0] pend8;

    assign pend8 = 8'(pending);

    // Scan in reverse search order so the first candidate wins last
    always_comb begin
        win_idx = '0;
        valid   = 1'b0;
        for (int j = N - 1; j >= 1; j--) begin
            int c;
            c = mode ? int'(last) + j : j;
            if (c > N - 1) c = c - (N - 1);
            if (pend8[c[2:0]]) begin
                win_idx = c[2:0];
                valid   = 1'b1;
            end
        end
    end

    assign winner = valid ? N'(8'd1 << win_idx) : '0;

endmodule

// File: rtl/minx_bus_fabric.sv
// Shared 24-bit bus fabric: owner/DMA arbitration, bus mux, read return.
// Master 0 owns the bus by default and must yield before any DMA grant.
module minx_bus_fabric
    import minx_bus_pkg::*;
#(
    parameter int          NUM_MASTERS = 2,
    parameter int          NUM_SLAVES  = 12,
    parameter int          ARB_MODE    = 0,
    parameter int          MAX_HOLD    = 4096,
    parameter logic [23:0] REG_BASE    = REG_BASE_DEFAULT,
    parameter int          IRQ_SLOT    = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_MASTERS-1:0]    m_req,
    input  logic [24*NUM_MASTERS-1:0] m_address,
    input  logic [8*NUM_MASTERS-1:0]  m_data_out,
    input  logic [NUM_MASTERS-1:0]    m_write,
    input  logic [NUM_MASTERS-1:0]    m_read,
    input  logic [2*NUM_MASTERS-1:0]  m_bus_status,
    input  logic                      owner_yield_ack,
    input  logic [7:0]                ext_data_in,
    input  logic [8*NUM_SLAVES-1:0]   slv_data,
    output logic [NUM_MASTERS-1:0]    m_gnt,
    output logic                      owner_yield_req,
    output logic [23:0]               address_out,
    output logic [7:0]                data_out,
    output logic                      write,
    output logic                      read,
    output logic [1:0]                bus_status,
    output logic [7:0]                m_data_in,
    output logic                      hold_timeout
);

    localparam int N  = NUM_MASTERS;
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);
    localparam logic HOLD_EN = (MAX_HOLD != 0);

    fab_state_t    state, state_n;
    logic [2:0]    cur, cur_n;
    logic [2:0]    rr_ptr, rr_n;
    logic [N-1:0]  mask, mask_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [N-1:0]  gnt_n;
    logic          yreq_n;
    logic          to_n;

    logic [N-1:0]  pending;
    logic [N-1:0]  others;
    logic [N-1:0]  cur_oh;
    logic          cur_req;
    logic          expire;
    logic [N-1:0]  pick_oh;
    logic [2:0]    pick_idx;
    logic          pick_valid;
    logic [7:0]    slot_or;

    assign pending = m_req & ~mask & ~N'(1);
    assign cur_oh  = N'(8'd1 << cur);
    assign others  = pending & ~cur_oh;
    assign cur_req = |(m_req & cur_oh);
    assign expire  = HOLD_EN && (cnt == CNT_LAST);

    minx_arb_pick #(
        .N(N)
    ) u_pick (
        .pending(pending),
        .last   (rr_ptr),
        .mode   (ARB_MODE != 0),
        .winner (pick_oh),
        .win_idx(pick_idx),
        .valid  (pick_valid)
    );

    // Next-state, watchdog, mask and registered-output computation
    always_comb begin
        state_n = state;
        cur_n   = cur;
        rr_n    = rr_ptr;
        cnt_n   = cnt;
        mask_n  = mask & m_req;
        gnt_n   = '0;
        unique case (state)
            FAB_OWNER: begin
                if (|pending) state_n = FAB_YIELD_WAIT;
            end
            FAB_YIELD_WAIT: begin
                if (!(|pending)) begin
                    state_n = FAB_RETURN;
                end else if (owner_yield_ack) begin
                    state_n = FAB_GRANT;
                    cur_n   = pick_idx;
                    rr_n    = pick_idx;
                    cnt_n   = '0;
                end
            end
            FAB_GRANT: begin
                if (!cur_req || expire) begin
                    if (expire) mask_n = mask_n | cur_oh;
                    state_n = (|others) ? FAB_HANDOVER : FAB_RETURN;
                end else if (HOLD_EN) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            FAB_HANDOVER: begin
                if (pick_valid) begin
                    state_n = FAB_GRANT;
                    cur_n   = pick_idx;
                    rr_n    = pick_idx;
                    cnt_n   = '0;
                end else begin
                    state_n = FAB_RETURN;
                end
            end
            FAB_RETURN: begin
                if (!owner_yield_ack) state_n = FAB_OWNER;
            end
            default: state_n = FAB_OWNER;
        endcase
        if (state_n == FAB_OWNER) gnt_n = N'(1);
        if (state_n == FAB_GRANT) begin
            gnt_n = (state == FAB_GRANT) ? cur_oh : pick_oh;
        end
        yreq_n = (state_n == FAB_YIELD_WAIT) ||
                 (state_n == FAB_GRANT) ||
                 (state_n == FAB_HANDOVER);
        to_n = (state_n == FAB_GRANT) && HOLD_EN &&
               (cnt_n == CNT_LAST);
    end

    // State, grant and handshake registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= FAB_OWNER;
            cur             <= '0;
            rr_ptr          <= '0;
            mask            <= '0;
            cnt             <= '0;
            m_gnt           <= N'(1);
            owner_yield_req <= 1'b0;
            hold_timeout    <= 1'b0;
        end else begin
            state           <= state_n;
            cur             <= cur_n;
            rr_ptr          <= rr_n;
            mask            <= mask_n;
            cnt             <= cnt_n;
            m_gnt           <= gnt_n;
            owner_yield_req <= yreq_n;
            hold_timeout    <= to_n;
        end
    end

    // One-hot grant makes an OR-mux sufficient; idle bus when ungranted
    always_comb begin
        address_out = '0;
        data_out    = '0;
        write       = 1'b0;
        read        = 1'b0;
        bus_status  = BUS_IDLE;
        for (int i = 0; i < N; i++) begin
            if (m_gnt[i]) begin
                address_out = address_out | m_address[24*i +: 24];
                data_out    = data_out | m_data_out[8*i +: 8];
                write       = write | m_write[i];
                read        = read | m_read[i];
                bus_status  = bus_status | m_bus_status[2*i +: 2];
            end
        end
    end

    // Unaddressed slots drive zero, so OR-reduce gives the addressed one
    always_comb begin
        slot_or = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            slot_or = slot_or | slv_data[8*s +: 8];
        end
    end

    // Read data return for the granted master
    always_comb begin
        m_data_in = ext_data_in;
        if (bus_status == BUS_IRQ_READ) begin
            m_data_in = slv_data[8*IRQ_SLOT +: 8];
        end else if (bus_status == BUS_MEM_READ &&
                     in_reg_window(address_out, REG_BASE)) begin
            m_data_in = slot_or;
        end
    end

endmodule

// File: tb/tb_minx_bus_fabric.sv
// Self-checking bench for minx_bus_fabric.
// Three instances cover N=2 watchdog/handshake and N=4 arbitration modes.
module tb_minx_bus_fabric;
    import minx_bus_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- N=2 instance, MAX_HOLD=8 ----------------
    logic [1:0]  req2, wr2, rd2, gnt2;
    logic [47:0] addr2;
    logic [15:0] dw2;
    logic [3:0]  bs2;
    logic        ack2, yreq2, to2, w2, r2;
    logic [7:0]  ext2, do2, din2;
    logic [95:0] slv2;
    logic [23:0] ao2;
    logic [1:0]  bso2;

    minx_bus_fabric #(
        .NUM_MASTERS(2), .ARB_MODE(0), .MAX_HOLD(8)
    ) u2 (
        .clk(clk), .reset(reset), .m_req(req2), .m_address(addr2),
        .m_data_out(dw2), .m_write(wr2), .m_read(rd2),
        .m_bus_status(bs2), .owner_yield_ack(ack2), .ext_data_in(ext2),
        .slv_data(slv2), .m_gnt(gnt2), .owner_yield_req(yreq2),
        .address_out(ao2), .data_out(do2), .write(w2), .read(r2),
        .bus_status(bso2), .m_data_in(din2), .hold_timeout(to2)
    );

    // ---------------- N=4 instances: [0] round robin, [1] fixed ----------
    logic [3:0]  req4 [2];
    logic [3:0]  gnt4 [2];
    logic [1:0]  ack4, yreq4, to4, w4, r4;
    logic [23:0] ao4 [2];
    logic [7:0]  do4 [2];
    logic [7:0]  din4 [2];
    logic [1:0]  bso4 [2];
    logic [95:0] addr4 = '0;
    logic [31:0] dw4 = '0;
    logic [3:0]  wr4 = '0, rd4 = '0;
    logic [7:0]  bs4 = '0;
    logic [7:0]  ext4 = '0;
    logic [95:0] slv4 = '0;

    minx_bus_fabric #(
        .NUM_MASTERS(4), .ARB_MODE(1)
    ) u4r (
        .clk(clk), .reset(reset), .m_req(req4[0]), .m_address(addr4),
        .m_data_out(dw4), .m_write(wr4), .m_read(rd4),
        .m_bus_status(bs4), .owner_yield_ack(ack4[0]), .ext_data_in(ext4),
        .slv_data(slv4), .m_gnt(gnt4[0]), .owner_yield_req(yreq4[0]),
        .address_out(ao4[0]), .data_out(do4[0]), .write(w4[0]),
        .read(r4[0]), .bus_status(bso4[0]), .m_data_in(din4[0]),
        .hold_timeout(to4[0])
    );

    minx_bus_fabric #(
        .NUM_MASTERS(4), .ARB_MODE(0)
    ) u4f (
        .clk(clk), .reset(reset), .m_req(req4[1]), .m_address(addr4),
        .m_data_out(dw4), .m_write(wr4), .m_read(rd4),
        .m_bus_status(bs4), .owner_yield_ack(ack4[1]), .ext_data_in(ext4),
        .slv_data(slv4), .m_gnt(gnt4[1]), .owner_yield_req(yreq4[1]),
        .address_out(ao4[1]), .data_out(do4[1]), .write(w4[1]),
        .read(r4[1]), .bus_status(bso4[1]), .m_data_in(din4[1]),
        .hold_timeout(to4[1])
    );

    typedef struct {
        logic [1:0]  bs;
        logic [23:0] addr;
        logic [7:0]  s0;
        logic [7:0]  s3;
        logic [7:0]  ext;
        logic [7:0]  exp;
        string       name;
    } vec_t;

    vec_t vecs [8];
    logic [7:0] sb_q [$];
    int         gq_r [$];
    int         gq_f [$];

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{BUS_MEM_READ,  24'h002010, 8'h00, 8'h18, 8'hA5, 8'h18, "reg_slot3"};
        vecs[1] = '{BUS_MEM_READ,  24'h002100, 8'h00, 8'h18, 8'hA5, 8'hA5, "above_window"};
        vecs[2] = '{BUS_IRQ_READ,  24'h000000, 8'h5A, 8'h18, 8'hA5, 8'h5A, "irq_vec"};
        vecs[3] = '{BUS_MEM_READ,  24'h001FFF, 8'h00, 8'h18, 8'h3C, 8'h3C, "below_window"};
        vecs[4] = '{BUS_MEM_READ,  24'h0020FF, 8'h01, 8'h10, 8'h3C, 8'h11, "window_top_or"};
        vecs[5] = '{BUS_MEM_READ,  24'h002000, 8'h40, 8'h02, 8'h3C, 8'h42, "window_base_or"};
        vecs[6] = '{BUS_MEM_WRITE, 24'h002010, 8'h00, 8'h18, 8'h77, 8'h77, "write_ext"};
        vecs[7] = '{BUS_IDLE,      24'h002010, 8'h00, 8'h18, 8'h66, 8'h66, "idle_ext"};

        reset = 1'b1;
        req2 = '0; wr2 = '0; rd2 = '0; bs2 = '0; ack2 = 1'b0;
        addr2 = '0; dw2 = '0; ext2 = '0; slv2 = '0;
        req4[0] = '0; req4[1] = '0; ack4 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // reset state
        check("rst_gnt2", gnt2, 2'b01);
        check("rst_yreq2", yreq2, 1'b0);
        check("rst_to2", to2, 1'b0);
        check("rst_gnt4", gnt4[0], 4'b0001);

        // read-return table on master 0 while it owns the bus
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bs2[1:0]    = vecs[i].bs;
            addr2[23:0] = vecs[i].addr;
            slv2        = '0;
            slv2[7:0]   = vecs[i].s0;
            slv2[31:24] = vecs[i].s3;
            ext2        = vecs[i].ext;
            sb_q.push_back(vecs[i].exp);
            #1;
            check({"rd_", vecs[i].name}, din2, sb_q.pop_front());
            check({"ao_", vecs[i].name}, ao2, vecs[i].addr);
            check({"bs_", vecs[i].name}, bso2, vecs[i].bs);
        end

        // N=2 request / yield / grant / release handshake
        @(negedge clk);
        bs2 = {BUS_MEM_WRITE, BUS_IDLE};
        addr2 = {24'h123456, 24'h000000};
        dw2 = 16'hC300;
        wr2 = 2'b10;
        req2[1] = 1'b1;
        @(negedge clk);
        check("yw_yreq", yreq2, 1'b1);
        check("yw_gnt", gnt2, 2'b00);
        check("yw_addr_zero", ao2, 24'h0);
        check("yw_bs_idle", bso2, BUS_IDLE);
        @(negedge clk);
        check("yw2_gnt", gnt2, 2'b00);
        ack2 = 1'b1;
        @(negedge clk);
        check("g_gnt", gnt2, 2'b10);
        check("g_addr", ao2, 24'h123456);
        check("g_data", do2, 8'hC3);
        check("g_write", w2, 1'b1);
        check("g_bs", bso2, BUS_MEM_WRITE);
        ack2 = 1'b0;
        @(negedge clk);
        check("ackdrop_hold", gnt2, 2'b10);
        ack2 = 1'b1;
        req2[1] = 1'b0;
        @(negedge clk);
        check("rel_gnt", gnt2, 2'b00);
        check("rel_yreq", yreq2, 1'b0);
        ack2 = 1'b0;
        @(negedge clk);
        check("own_back", gnt2, 2'b01);

        // watchdog: master 1 holds the bus past MAX_HOLD
        req2[1] = 1'b1;
        ack2 = 1'b1;
        begin
            int g, to_at, pulses;
            bit ended;
            g = 0; to_at = -1; pulses = 0; ended = 1'b0;
            for (int c = 0; c < 40 && !ended; c++) begin
                @(negedge clk);
                if (to2) pulses++;
                if (gnt2 == 2'b10) begin
                    g++;
                    if (to2) to_at = g;
                end else if (g > 0) begin
                    ended = 1'b1;
                end
            end
            check("wd_ended", ended, 1'b1);
            check("wd_grant_cycles", g, 8);
            check("wd_pulse_at", to_at, 8);
            check("wd_one_pulse", pulses, 1);
            check("wd_gnt_off", gnt2, 2'b00);
        end
        ack2 = 1'b0;
        @(negedge clk);
        begin
            int badc;
            badc = 0;
            for (int c = 0; c < 6; c++) begin
                if (gnt2 != 2'b01 || yreq2 != 1'b0) badc++;
                @(negedge clk);
            end
            check("wd_masked", badc, 0);
        end
        req2[1] = 1'b0;
        @(negedge clk);
        req2[1] = 1'b1;
        ack2 = 1'b1;
        begin
            bit got;
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                if (gnt2 == 2'b10) got = 1'b1;
            end
            check("wd_regrant", got, 1'b1);
        end

        // reset while granted
        reset = 1'b1;
        @(negedge clk);
        check("rstg_gnt", gnt2, 2'b01);
        check("rstg_yreq", yreq2, 1'b0);
        check("rstg_to", to2, 1'b0);
        reset = 1'b0;
        req2 = '0;
        ack2 = 1'b0;
        @(negedge clk);

        // request withdrawn while waiting for the yield
        req2[1] = 1'b1;
        @(negedge clk);
        check("wd_yw_yreq", yreq2, 1'b1);
        req2[1] = 1'b0;
        ack2 = 1'b1;
        @(negedge clk);
        check("wdr_gnt", gnt2, 2'b00);
        check("wdr_yreq", yreq2, 1'b0);
        @(negedge clk);
        check("wdr_wait_ack", gnt2, 2'b00);
        ack2 = 1'b0;
        @(negedge clk);
        check("wdr_owner", gnt2, 2'b01);

        // N=4 arbitration: round robin vs fixed priority
        gq_r = '{1, 2, 3, 1};
        gq_f = '{1, 1, 1, 1};
        req4[0] = 4'b1110;
        req4[1] = 4'b1110;
        begin
            int gc [2][4];
            int ngr [2];
            int zrun [2];
            logic [3:0] prev [2];
            for (int d = 0; d < 2; d++) begin
                ngr[d] = 0; zrun[d] = 0; prev[d] = 4'b0001;
                for (int k = 0; k < 4; k++) gc[d][k] = 0;
            end
            for (int c = 0; c < 300 && (ngr[0] < 4 || ngr[1] < 4); c++) begin
                @(negedge clk);
                for (int d = 0; d < 2; d++) begin
                    logic [3:0] g;
                    g = gnt4[d];
                    if (g[3:1] != 3'b0 && prev[d] == 4'b0 && ngr[d] < 4) begin
                        int idx, e;
                        idx = 0;
                        for (int k = 1; k < 4; k++) if (g[k]) idx = k;
                        e = (d == 0) ? gq_r.pop_front() : gq_f.pop_front();
                        check(d == 0 ? "rr_order" : "fx_order", idx, e);
                        check(d == 0 ? "rr_onehot" : "fx_onehot",
                              $countones(g), 1);
                        if (ngr[d] > 0)
                            check(d == 0 ? "rr_gap" : "fx_gap", zrun[d], 1);
                        ngr[d]++;
                    end
                    zrun[d] = (g == 4'b0) ? zrun[d] + 1 : 0;
                    for (int k = 1; k < 4; k++) begin
                        if (g[k]) begin
                            gc[d][k]++;
                            if (gc[d][k] == 5) begin
                                req4[d][k] = 1'b0;
                                gc[d][k] = 0;
                            end
                        end else if (!req4[d][k]) begin
                            req4[d][k] = 1'b1;
                        end
                    end
                    ack4[d] = yreq4[d];
                    prev[d] = g;
                end
            end
            check("rr_grants_seen", ngr[0], 4);
            check("fx_grants_seen", ngr[1], 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
